seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
// - Parametrised serial sequence detector; next generation of the fixed "101" FSM detector.
// - Adds any pattern width, a pattern loadable at runtime, overlap/non-overlap mode,
//   input qualification (valid), a saturating match counter and a sync clear.
// - Sits between a bit-serial source (UART/LFSR/test stimulus) and status/interrupt logic.
// PARAMETERS
// - PATTERN_W   3       pattern length in bits, >= 2
// - PATTERN_RST 3'b101  pattern loaded on reset; MSB = oldest bit in time
// - CNT_W       8       width of match counter, >= 1
// PORTS
// - clk          in   1          single clock, rising edge
// - rst_n        in   1          async assert, active-low reset; the only reset
// - clear        in   1          sync clear of history, fill count, match_cnt and cnt_sat
// - cfg_load     in   1          load cfg_pattern; also flushes history and fill
// - cfg_pattern  in   PATTERN_W  new pattern, MSB oldest
// - overlap_en   in   1          1 = overlapping matches allowed, 0 = restart after match
// - din_valid    in   1          din qualifier; bit consumed only when high
// - din          in   1          serial data bit
// - match        out  1          1-cycle pulse: pattern completed by the last consumed bit
// - match_cnt    out  CNT_W      number of matches since reset/clear, saturating
// - cnt_sat      out  1          sticky: match_cnt reached all-ones
// - pattern      out  PATTERN_W  currently active pattern
// BEHAVIOUR
// - Reset (rst_n=0, async): hist=0, fill=0, match=0, match_cnt=0, cnt_sat=0, pattern=PATTERN_RST.
// - hist: PATTERN_W shift register; on consumed bit, hist <= {hist[PATTERN_W-2:0], din}.
// - fill: 0..PATTERN_W, counts consumed bits since last flush; saturates at PATTERN_W.
// - FSM states: FILL (fill<PATTERN_W) and ARMED (fill==PATTERN_W); reached by consumed bits only.
// - Hit condition (combinational, same cycle as bit): din_valid & ({hist[W-2:0],din}==pattern)
//   & (fill >= PATTERN_W-1).
// - match registered: asserted exactly 1 cycle after the edge sampling the completing bit;
//   low in every other cycle, including cycles with din_valid=0.
// - overlap_en=1 on hit: fill stays/becomes PATTERN_W (suffix of a match may start the next).
// - overlap_en=0 on hit: fill <= 0 and hist <= 0; next match needs PATTERN_W fresh bits.
// - overlap_en is sampled each cycle; a change affects only the hit decision of that cycle.
// - match_cnt increments by 1 on the cycle match rises; holds at all-ones, cnt_sat sets then
//   and stays set until clear or reset.
// - Priority each cycle: rst_n > clear > cfg_load > din_valid.
//   - clear: hist, fill, match_cnt, cnt_sat, match <= 0; pattern kept; din dropped.
//   - cfg_load: pattern <= cfg_pattern, hist/fill <= 0, match <= 0; din dropped; counter kept.
//   - clear & cfg_load together: both effects applied; pattern loaded.
// - din_valid=0: hist, fill unchanged (gaps are transparent to the pattern).
// - Reset mid-stream: partial progress discarded, pattern reverts to PATTERN_RST.
// - All-zero pattern is legal; matches only after PATTERN_W valid zeros.
// STRUCTURE
// - Package seq_det_pkg: FSM state encodings (ST_FILL, ST_ARMED), fill width function
//   ($clog2(PATTERN_W+1)), mode constants OVL_ON/OVL_OFF.
// - Sub-module sat_counter (CNT_W, inc, clr -> cnt, sat) instantiated for match_cnt/cnt_sat.
// - Top holds pattern reg, hist shift reg, fill counter/FSM, registered match.
// TESTING
// - Defaults, overlap_en=1, din 1,0,1,0,1 all valid -> match pulses after bits 3 and 5; match_cnt=2.
// - Same stream, overlap_en=0 -> single match after bit 3; match_cnt=1.
// - din_valid gaps: 1,(gap x3),0,(gap),1 -> exactly one match, 1 cycle after final bit; none in gaps.
// - CNT_W=2, overlap_en=1, stream 1,0,1,0,1,0,1,0,1,0,1 (5 matches) -> match_cnt=3, cnt_sat=1; clear -> 0,0.
// - PATTERN_W=8: cfg_load 8'hA5 mid-stream, then feed 1010_0101 -> one match; prior partial bits ignored.
// - rst_n low after 1,0 of a 101 stream, release, feed 1 -> no match; pattern reads 3'b101.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared encodings and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } det_state_e;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // Width needed to hold a fill count of 0..w inclusive.
    function automatic int fill_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating event counter with a sticky flag raised when the count reaches all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_MAX - CNT_W'(1))
                sat <= 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: runtime-loadable pattern, overlap control, valid-qualified input,
// registered one-cycle match pulse and a saturating match counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W   = 3,
    parameter logic [PATTERN_W-1:0] PATTERN_RST = 3'b101,
    parameter int                   CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 cfg_load,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic                 overlap_en,
    input  logic                 din_valid,
    input  logic                 din,
    output logic                 match,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 cnt_sat,
    output logic [PATTERN_W-1:0] pattern
);

    localparam int             FW       = fill_w(PATTERN_W);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PATTERN_W);
    localparam logic [FW-1:0]  FILL_ARM = FW'(PATTERN_W - 1);

    logic [PATTERN_W-1:0] hist;
    logic [PATTERN_W-1:0] shifted;
    logic [FW-1:0]        fill;
    det_state_e           state;
    logic                 consume;
    logic                 hit;

    // clear and cfg_load both drop the incoming bit, so it never reaches the window.
    assign consume = din_valid & ~clear & ~cfg_load;
    assign shifted = {hist[PATTERN_W-2:0], din};
    assign hit     = consume & (shifted == pattern) & (fill >= FILL_ARM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist    <= '0;
            fill    <= '0;
            state   <= ST_FILL;
            match   <= 1'b0;
            pattern <= PATTERN_RST;
        end else begin
            match <= 1'b0;
            if (clear || cfg_load) begin
                hist  <= '0;
                fill  <= '0;
                state <= ST_FILL;
                if (cfg_load)
                    pattern <= cfg_pattern;
            end else if (consume) begin
                if (hit) begin
                    match <= 1'b1;
                    if (overlap_en == OVL_ON) begin
                        // Suffix of this match may seed the next one.
                        hist  <= shifted;
                        fill  <= FILL_MAX;
                        state <= ST_ARMED;
                    end else begin
                        hist  <= '0;
                        fill  <= '0;
                        state <= ST_FILL;
                    end
                end else begin
                    hist <= shifted;
                    if (state == ST_FILL) begin
                        fill  <= fill + FW'(1);
                        state <= (fill == FILL_ARM) ? ST_ARMED : ST_FILL;
                    end
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (clear),
        .cnt   (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Drives three detector configurations from shared stimulus and checks each against a
// bit-window reference model every cycle, plus directed literal expectations.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic       overlap_en = 1'b1;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;

    always #5 clk = ~clk;

    logic       m3, m2, m8, s3, s2, s8;
    logic [7:0] c3, c8;
    logic [1:0] c2;
    logic [2:0] p3, p2;
    logic [7:0] p8;

    seq_detect_param u_d3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern[2:0]), .overlap_en(overlap_en), .din_valid(din_valid),
        .din(din), .match(m3), .match_cnt(c3), .cnt_sat(s3), .pattern(p3)
    );

    seq_detect_param #(.PATTERN_W(3), .PATTERN_RST(3'b101), .CNT_W(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern[2:0]), .overlap_en(overlap_en), .din_valid(din_valid),
        .din(din), .match(m2), .match_cnt(c2), .cnt_sat(s2), .pattern(p2)
    );

    seq_detect_param #(.PATTERN_W(8), .PATTERN_RST(8'h3C), .CNT_W(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .overlap_en(overlap_en), .din_valid(din_valid),
        .din(din), .match(m8), .match_cnt(c8), .cnt_sat(s8), .pattern(p8)
    );

    logic       a_match[3];
    logic [7:0] a_cnt[3];
    logic       a_sat[3];
    logic [7:0] a_pat[3];
    assign a_match[0] = m3;  assign a_match[1] = m2;  assign a_match[2] = m8;
    assign a_cnt[0] = c3;    assign a_cnt[1] = {6'b0, c2}; assign a_cnt[2] = c8;
    assign a_sat[0] = s3;    assign a_sat[1] = s2;    assign a_sat[2] = s8;
    assign a_pat[0] = {5'b0, p3}; assign a_pat[1] = {5'b0, p2}; assign a_pat[2] = p8;

    // Reference model: pattern width, counter width, reset pattern per instance.
    int         pw[3]      = '{3, 3, 8};
    int         cw[3]      = '{8, 2, 8};
    logic [7:0] rst_pat[3] = '{8'h05, 8'h05, 8'h3C};

    logic [7:0] m_pat[3];
    logic [7:0] m_win[3];
    int         m_seen[3];
    int         m_cnt[3];
    logic       m_sat[3];
    logic       m_match[3];

    int total = 0;
    int bad = 0;
    logic [7:0] mseq;

    task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, i, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pat[i] = rst_pat[i];
            m_win[i] = 8'h00;
            m_seen[i] = 0;
            m_cnt[i] = 0;
            m_sat[i] = 1'b0;
            m_match[i] = 1'b0;
        end
    endtask

    // One consumed-or-not clock edge, expressed as "last W bits since the last flush".
    task automatic model_step();
        int mask, maxc;
        logic [7:0] nw;
        for (int i = 0; i < 3; i++) begin
            mask = (1 << pw[i]) - 1;
            maxc = (1 << cw[i]) - 1;
            m_match[i] = 1'b0;
            if (clear) begin
                m_cnt[i] = 0;
                m_sat[i] = 1'b0;
            end
            if (clear || cfg_load) begin
                m_seen[i] = 0;
                m_win[i] = 8'h00;
                if (cfg_load) m_pat[i] = cfg_pattern & 8'(mask);
            end else if (din_valid) begin
                nw = 8'((({24'b0, m_win[i]} << 1) | {31'b0, din}) & mask);
                if (m_seen[i] + 1 >= pw[i] && nw == m_pat[i]) begin
                    m_match[i] = 1'b1;
                    if (m_cnt[i] < maxc) m_cnt[i]++;
                    if (m_cnt[i] == maxc) m_sat[i] = 1'b1;
                    if (overlap_en) begin
                        m_win[i] = nw;
                        m_seen[i]++;
                    end else begin
                        m_win[i] = 8'h00;
                        m_seen[i] = 0;
                    end
                end else begin
                    m_win[i] = nw;
                    m_seen[i]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk("match", i, {7'b0, a_match[i]}, {7'b0, m_match[i]});
            chk("match_cnt", i, a_cnt[i], 8'(m_cnt[i]));
            chk("cnt_sat", i, {7'b0, a_sat[i]}, {7'b0, m_sat[i]});
            chk("pattern", i, a_pat[i], m_pat[i]);
        end
    endtask

    // Called at a negedge: drive, let the edge happen, advance model, check at next negedge.
    task automatic cyc(input logic c, input logic l, input logic [7:0] p,
                       input logic ov, input logic v, input logic d);
        clear = c; cfg_load = l; cfg_pattern = p; overlap_en = ov; din_valid = v; din = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input int k, input logic ov, input logic d);
        cyc(1'b0, 1'b0, 8'h00, ov, 1'b1, d);
        mseq = {mseq[6:0], a_match[k]};
    endtask

    task automatic gap(input int k);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        mseq = {mseq[6:0], a_match[k]};
    endtask

    task automatic do_clear();
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] a5 = 8'hA5;
    int r;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_pat3", 0, a_pat[0], 8'h05);
        chk("rst_pat8", 2, a_pat[2], 8'h3C);
        rst_n = 1'b1;

        // 1,0,1,0,1 with overlap: pulses after bits 3 and 5
        mseq = 0;
        send(0, 1, 1); send(0, 1, 0); send(0, 1, 1); send(0, 1, 0); send(0, 1, 1);
        chk("ovl_seq", 0, mseq, 8'b0000_0101);
        chk("ovl_cnt", 0, a_cnt[0], 8'd2);

        // same stream, non-overlap: single pulse after bit 3
        do_clear();
        mseq = 0;
        send(0, 0, 1); send(0, 0, 0); send(0, 0, 1); send(0, 0, 0); send(0, 0, 1);
        chk("novl_seq", 0, mseq, 8'b0000_0100);
        chk("novl_cnt", 0, a_cnt[0], 8'd1);

        // valid gaps are transparent
        do_clear();
        mseq = 0;
        send(0, 1, 1); gap(0); gap(0); gap(0); send(0, 1, 0); gap(0); send(0, 1, 1);
        gap(0);
        chk("gap_seq", 0, mseq, 8'b0000_0010);
        chk("gap_cnt", 0, a_cnt[0], 8'd1);

        // 5 overlapping matches saturate the 2-bit counter
        do_clear();
        for (int n = 0; n < 11; n++) send(1, 1, 1'((n + 1) % 2));
        chk("sat_cnt2", 1, a_cnt[1], 8'd3);
        chk("sat_flag2", 1, {7'b0, a_sat[1]}, 8'd1);
        chk("sat_cnt8", 0, a_cnt[0], 8'd5);
        chk("sat_flag8", 0, {7'b0, a_sat[0]}, 8'd0);
        do_clear();
        chk("clr_cnt2", 1, a_cnt[1], 8'd0);
        chk("clr_sat2", 1, {7'b0, a_sat[1]}, 8'd0);

        // width 8: partial bits then load A5; stale bits must not count
        send(2, 1, 1); send(2, 1, 0); send(2, 1, 1);
        cyc(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        chk("ld_pat8", 2, a_pat[2], 8'hA5);
        mseq = 0;
        for (int n = 7; n >= 0; n--) send(2, 1, a5[n]);
        chk("a5_seq", 2, mseq, 8'b0000_0001);
        chk("a5_cnt", 2, a_cnt[2], 8'd1);

        // all-zero pattern on the 3-bit detector
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        mseq = 0;
        send(0, 1, 0); send(0, 1, 0); send(0, 1, 0);
        chk("zero_seq", 0, mseq, 8'b0000_0001);

        // reset mid-stream drops progress and restores the pattern
        do_reset();
        send(0, 1, 1); send(0, 1, 0);
        do_reset();
        mseq = 0;
        send(0, 1, 1);
        chk("rst_mid_match", 0, mseq, 8'b0000_0000);
        chk("rst_mid_pat", 0, a_pat[0], 8'h05);
        chk("rst_mid_pat8", 2, a_pat[2], 8'h3C);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else begin
                cyc(1'(r < 3), 1'(r >= 3 && r < 8),
                    (r % 2 == 0) ? 8'hA5 : 8'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
